or1200_vlx_packer: RTL and testbench

- Parametrised, buffered successor to the OR1200 VLX bit-packing unit for the JPEG entropy coder.
- Accepts variable-length codes from set-bit instructions into a wide accumulator and extracts bytes with JPEG byte stuffing (FF→FF 00).
- Queues bytes in a small FIFO and drains them to memory through the byte-store handshake.
- Stalls the CPU only when the accumulator cannot accept a code, or while a flush is in progress.

---
 rtl/or1200_vlx_pkg.sv | 18 +
 rtl/or1200_vlx_byte_fifo.sv | 48 ++++
 rtl/or1200_vlx_packer.sv | 183 ++++++++++++++++++
 tb/tb_or1200_vlx_packer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/or1200_vlx_pkg.sv
// Shared constants and types for the VLX bit packer: SPR indices,
// extractor states and the JPEG byte-stuffing values.
package or1200_vlx_pkg;

    localparam logic [1:0] VLX_SPR_CTRL = 2'd0;
    localparam logic [1:0] VLX_SPR_CNT  = 2'd1;
    localparam logic [1:0] VLX_SPR_ADDR = 2'd2;
    localparam logic [1:0] VLX_SPR_LVL  = 2'd3;

    typedef enum logic {
        VLX_IDLE  = 1'b0,
        VLX_STUFF = 1'b1
    } vlx_state_e;

    localparam logic [7:0] VLX_STUFF_BYTE = 8'hFF;
    localparam logic [7:0] VLX_STUFF_ZERO = 8'h00;

endpackage

// File: rtl/or1200_vlx_byte_fifo.sv
// Small byte FIFO between the bit extractor and the store port.
// DEPTH must be a power of two so the pointers wrap naturally.
module or1200_vlx_byte_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [7:0]       din,
    input  logic             pop,
    output logic [7:0]       dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/or1200_vlx_packer.sv
// VLX bit packer: accumulates variable-length codes, extracts bytes with
// JPEG FF->FF 00 stuffing, and drains them through the byte-store port.
module or1200_vlx_packer
    import or1200_vlx_pkg::*;
#(
    parameter  int          ACC_W      = 32,
    parameter  int          MAX_BITS   = 16,
    parameter  int          FIFO_DEPTH = 4,
    parameter  logic [31:0] RST_ADDR   = 32'h0383c1d0,
    localparam int          LEN_W      = $clog2(MAX_BITS + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                set_bit_op_i,
    input  logic [LEN_W-1:0]    num_bits_i,
    input  logic [MAX_BITS-1:0] dat_i,
    input  logic                spr_cs,
    input  logic                spr_write,
    input  logic [1:0]          spr_addr,
    input  logic [31:0]         spr_dat_i,
    output logic [31:0]         spr_dat_o,
    output logic                stall_cpu_o,
    output logic                store_byte_o,
    output logic [31:0]         vlx_addr_o,
    output logic [31:0]         dat_o,
    input  logic                ack_i
);

    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam int IDX_W = $clog2(ACC_W);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic [ACC_W-1:0]    acc, acc_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    vlx_state_e          state, state_next;
    logic                flushing;
    logic                err;
    logic [31:0]         byte_count;

    logic [LEN_W-1:0]    n_eff;
    logic [MAX_BITS-1:0] code;
    logic                accept;
    logic [3:0]          pad_n;
    logic                pad;
    logic [IDX_W-1:0]    ext_lsb;
    logic [7:0]          ext_byte;
    logic                extract;
    logic                push;
    logic [7:0]          push_byte;

    logic                fifo_full, fifo_empty;
    logic [7:0]          fifo_head;
    logic [LVL_W-1:0]    fifo_level;

    logic                ack_fire;
    logic                spr_wr;
    logic                idle;
    logic                flush_done;

    assign n_eff = (num_bits_i > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : num_bits_i;

    always_comb begin
        code = '0;
        for (int i = 0; i < MAX_BITS; i++) begin
            code[i] = dat_i[i] && (i < int'(n_eff));
        end
    end

    // Accept is judged on the current fill; a same-cycle extraction does not help.
    assign accept      = set_bit_op_i && !flushing && (int'(cnt) + int'(n_eff) <= ACC_W);
    assign stall_cpu_o = (set_bit_op_i && !accept) || flushing;

    assign pad_n = 4'd8 - {1'b0, cnt[2:0]};
    assign pad   = flushing && (cnt[2:0] != 3'd0) && (int'(cnt) + int'(pad_n) <= ACC_W);

    assign ext_lsb  = IDX_W'(cnt - CNT_W'(8));
    assign ext_byte = acc[ext_lsb +: 8];

    always_comb begin
        state_next = state;
        push       = 1'b0;
        push_byte  = ext_byte;
        extract    = 1'b0;
        case (state)
            VLX_IDLE: begin
                if (cnt >= CNT_W'(8) && !fifo_full) begin
                    push    = 1'b1;
                    extract = 1'b1;
                    if (ext_byte == VLX_STUFF_BYTE) state_next = VLX_STUFF;
                end
            end
            VLX_STUFF: begin
                if (!fifo_full) begin
                    push       = 1'b1;
                    push_byte  = VLX_STUFF_ZERO;
                    state_next = VLX_IDLE;
                end
            end
        endcase
    end

    // Stale bits above cnt are never read, so the shift needs no masking.
    always_comb begin
        acc_next = acc;
        cnt_next = cnt;
        if (accept) begin
            acc_next = (acc << n_eff) | ACC_W'(code);
            cnt_next = cnt + CNT_W'(n_eff);
        end else if (pad) begin
            acc_next = (acc << pad_n) | ACC_W'(VLX_STUFF_BYTE >> cnt[2:0]);
            cnt_next = cnt + CNT_W'(pad_n);
        end
        if (extract) cnt_next = cnt_next - CNT_W'(8);
    end

    or1200_vlx_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .din   (push_byte),
        .pop   (ack_fire),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign ack_fire   = store_byte_o && ack_i;
    assign spr_wr     = spr_cs && spr_write;
    assign idle       = fifo_empty && (cnt == '0) && !store_byte_o;
    assign flush_done = (cnt == '0) && fifo_empty && (state == VLX_IDLE) && !store_byte_o;
    assign dat_o      = {24'h0, store_byte_o ? fifo_head : 8'h00};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc          <= '0;
            cnt          <= '0;
            state        <= VLX_IDLE;
            flushing     <= 1'b0;
            err          <= 1'b0;
            byte_count   <= '0;
            store_byte_o <= 1'b0;
            vlx_addr_o   <= RST_ADDR;
        end else begin
            acc   <= acc_next;
            cnt   <= cnt_next;
            state <= state_next;

            // The head stays put until acked, so the request can stay up back-to-back.
            if (ack_fire) store_byte_o <= (fifo_level > LVL_W'(1)) || push;
            else          store_byte_o <= !fifo_empty;

            if (flushing) begin
                if (flush_done) flushing <= 1'b0;
            end else if (spr_wr && spr_addr == VLX_SPR_CTRL && spr_dat_i[0]) begin
                flushing <= 1'b1;
            end

            if (spr_wr && spr_addr == VLX_SPR_CTRL && spr_dat_i[1]) err <= 1'b0;
            else if (spr_wr && spr_addr == VLX_SPR_ADDR && !idle)   err <= 1'b1;

            if (spr_wr && spr_addr == VLX_SPR_CNT) byte_count <= '0;
            else if (ack_fire)                     byte_count <= byte_count + 32'd1;

            if (spr_wr && spr_addr == VLX_SPR_ADDR && idle) vlx_addr_o <= spr_dat_i;
            else if (ack_fire)                              vlx_addr_o <= vlx_addr_o + 32'd1;
        end
    end

    always_comb begin
        spr_dat_o = '0;
        case (spr_addr)
            VLX_SPR_CTRL: spr_dat_o = {err, flushing, 22'h0, 8'(cnt)};
            VLX_SPR_CNT:  spr_dat_o = byte_count;
            VLX_SPR_ADDR: spr_dat_o = vlx_addr_o;
            VLX_SPR_LVL:  spr_dat_o = 32'(fifo_level);
            default:      spr_dat_o = '0;
        endcase
    end

endmodule

// File: tb/tb_or1200_vlx_packer.sv
// Bench for or1200_vlx_packer: bit-stream/queue reference model compared
// every cycle, directed scenarios with literal expectations, random phase.
module tb_or1200_vlx_packer;

  localparam int          ACC_W      = 32;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] RST_ADDR   = 32'h0383c1d0;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        set_bit_op_i = 1'b0;
  logic [4:0]  num_bits_i = '0;
  logic [15:0] dat_i = '0;
  logic        spr_cs = 1'b0;
  logic        spr_write = 1'b0;
  logic [1:0]  spr_addr = '0;
  logic [31:0] spr_dat_i = '0;
  logic [31:0] spr_dat_o;
  logic        stall_cpu_o;
  logic        store_byte_o;
  logic [31:0] vlx_addr_o;
  logic [31:0] dat_o;
  logic        ack_i = 1'b0;

  int checks = 0;
  int errors = 0;
  int ack_mode = 0;

  // clock / reset
  always #5 clk = ~clk;

  or1200_vlx_packer dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .set_bit_op_i (set_bit_op_i),
    .num_bits_i   (num_bits_i),
    .dat_i        (dat_i),
    .spr_cs       (spr_cs),
    .spr_write    (spr_write),
    .spr_addr     (spr_addr),
    .spr_dat_i    (spr_dat_i),
    .spr_dat_o    (spr_dat_o),
    .stall_cpu_o  (stall_cpu_o),
    .store_byte_o (store_byte_o),
    .vlx_addr_o   (vlx_addr_o),
    .dat_o        (dat_o),
    .ack_i        (ack_i)
  );

  // reference model: pending bits oldest-first, queued bytes, port state
  bit          m_bits[$];
  logic [7:0]  exp_q[$];
  bit          m_stuff = 0;
  bit          m_store = 0;
  bit          m_flushing = 0;
  bit          m_err = 0;
  logic [31:0] m_addr = RST_ADDR;
  logic [31:0] m_bcount = '0;

  logic [7:0]  log_q[$];
  logic [31:0] alog_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int n;
    int old_sz;
    int pad;
    bit acc_ok;
    bit fire;
    bit push;
    bit idle;
    bit done;
    bit wr;
    logic [7:0] pb;
    n      = (num_bits_i > 16) ? 16 : int'(num_bits_i);
    acc_ok = set_bit_op_i && !m_flushing && (m_bits.size() + n <= ACC_W);
    old_sz = exp_q.size();
    fire   = m_store && ack_i;
    idle   = (old_sz == 0) && (m_bits.size() == 0) && !m_store;
    done   = m_flushing && (m_bits.size() == 0) && (old_sz == 0) && !m_stuff && !m_store;
    pad    = (m_flushing && (m_bits.size() % 8 != 0)) ? 8 - (m_bits.size() % 8) : 0;
    wr     = spr_cs && spr_write;
    push   = 0;
    pb     = 8'h00;
    if (old_sz < FIFO_DEPTH) begin
      if (m_stuff) begin
        push = 1;
        m_stuff = 0;
      end else if (m_bits.size() >= 8) begin
        for (int i = 0; i < 8; i++) pb = {pb[6:0], m_bits.pop_front()};
        push = 1;
        m_stuff = (pb == 8'hFF);
      end
    end
    if (acc_ok) for (int i = n - 1; i >= 0; i--) m_bits.push_back(dat_i[i]);
    for (int i = 0; i < pad; i++) m_bits.push_back(1'b1);
    if (fire) begin
      void'(exp_q.pop_front());
      m_addr = m_addr + 32'd1;
      m_bcount = m_bcount + 32'd1;
    end
    if (push) exp_q.push_back(pb);
    m_store = fire ? (exp_q.size() > 0) : (old_sz > 0);
    if (m_flushing) begin
      if (done) m_flushing = 0;
    end else if (wr && spr_addr == 2'd0 && spr_dat_i[0]) begin
      m_flushing = 1;
    end
    if (wr && spr_addr == 2'd0 && spr_dat_i[1]) m_err = 0;
    if (wr && spr_addr == 2'd1) m_bcount = '0;
    if (wr && spr_addr == 2'd2) begin
      if (idle) m_addr = spr_dat_i;
      else m_err = 1;
    end
  endtask

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      m_bits.delete();
      exp_q.delete();
      m_stuff = 0;
      m_store = 0;
      m_flushing = 0;
      m_err = 0;
      m_addr = RST_ADDR;
      m_bcount = '0;
    end else begin
      model_step();
    end
  end

  // compare process: outputs settled, away from both edges
  int          c_n;
  bit          c_stall;
  logic [31:0] c_spr;
  always @(negedge clk) begin
    #2;
    c_n = (num_bits_i > 16) ? 16 : int'(num_bits_i);
    c_stall = (set_bit_op_i && !(!m_flushing && (m_bits.size() + c_n <= ACC_W))) || m_flushing;
    check("stall", stall_cpu_o, c_stall);
    check("store", store_byte_o, m_store);
    check("addr", vlx_addr_o, m_addr);
    if (m_store && exp_q.size() > 0) check("dat", dat_o, {24'h0, exp_q[0]});
    case (spr_addr)
      2'd0:    c_spr = {m_err, m_flushing, 22'h0, 8'(m_bits.size())};
      2'd1:    c_spr = m_bcount;
      2'd2:    c_spr = m_addr;
      default: c_spr = 32'(exp_q.size());
    endcase
    check("spr", spr_dat_o, c_spr);
    if (store_byte_o && ack_i && !rst_i) begin
      log_q.push_back(dat_o[7:0]);
      alog_q.push_back(vlx_addr_o);
    end
  end

  always @(negedge clk) begin
    case (ack_mode)
      0:       ack_i = 1'b0;
      1:       ack_i = 1'b1;
      default: ack_i = ($urandom_range(0, 2) != 0);
    endcase
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic spr_wr_t(input logic [1:0] a, input logic [31:0] d);
    spr_cs = 1'b1;
    spr_write = 1'b1;
    spr_addr = a;
    spr_dat_i = d;
    tick();
    spr_cs = 1'b0;
    spr_write = 1'b0;
    spr_dat_i = '0;
  endtask

  task automatic spr_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    spr_addr = a;
    #1;
    check(name, spr_dat_o, exp);
    tick();
  endtask

  task automatic do_op(input int n, input logic [15:0] d);
    bit ok;
    ok = 0;
    set_bit_op_i = 1'b1;
    num_bits_i = 5'(n);
    dat_i = d;
    for (int k = 0; k < 200 && !ok; k++) begin
      #3;
      ok = !stall_cpu_o;
      tick();
    end
    set_bit_op_i = 1'b0;
    check("op_accept", ok, 1);
  endtask

  task automatic try_op(input int n, input logic [15:0] d, output bit ok);
    set_bit_op_i = 1'b1;
    num_bits_i = 5'(n);
    dat_i = d;
    #3;
    ok = !stall_cpu_o;
    tick();
    set_bit_op_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      tick();
      ok = (m_bits.size() == 0) && (exp_q.size() == 0) && !m_store && !m_flushing && !m_stuff;
    end
    tick();
    check("drain_timeout", ok, 1);
  endtask

  task automatic wait_store();
    bit ok;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      tick();
      ok = store_byte_o;
    end
    check("store_timeout", ok, 1);
  endtask

  int acc_cnt;
  bit stall_seen;
  bit ok_op;
  int r;

  initial begin
    #1 rst_i = 1'b1;
    repeat (3) tick();
    #1;
    check("rst_store", store_byte_o, 0);
    check("rst_addr", vlx_addr_o, RST_ADDR);
    check("rst_dat", dat_o, 0);
    check("rst_stall", stall_cpu_o, 0);
    tick();
    rst_i = 1'b0;
    tick();

    // single byte
    ack_mode = 1;
    spr_wr_t(2'd2, 32'h0000_1000);
    log_q.delete(); alog_q.delete();
    do_op(8, 16'h00A5);
    wait_idle(100);
    check("t1_len", log_q.size(), 1);
    if (log_q.size() == 1) begin
      check("t1_byte", log_q[0], 8'hA5);
      check("t1_baddr", alog_q[0], 32'h1000);
    end
    spr_rd(2'd1, 32'd1, "t1_bcount");
    check("t1_addr", vlx_addr_o, 32'h1001);

    // FF stuffing
    spr_wr_t(2'd1, 32'h0);
    log_q.delete(); alog_q.delete();
    do_op(8, 16'h00FF);
    wait_idle(100);
    check("t2_len", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t2_b0", log_q[0], 8'hFF);
      check("t2_b1", log_q[1], 8'h00);
      check("t2_a0", alog_q[0], 32'h1001);
      check("t2_a1", alog_q[1], 32'h1002);
    end
    spr_rd(2'd1, 32'd2, "t2_bcount");

    // partial byte + flush pads with ones
    log_q.delete(); alog_q.delete();
    do_op(4, 16'h000A);
    spr_wr_t(2'd0, 32'h1);
    #1 check("t3_flush_stall", stall_cpu_o, 1);
    wait_idle(100);
    check("t3_len", log_q.size(), 1);
    if (log_q.size() == 1) begin
      check("t3_byte", log_q[0], 8'hAF);
      check("t3_baddr", alog_q[0], 32'h1003);
    end
    spr_rd(2'd0, 32'h0, "t3_ctrl");

    // back-pressure: FIFO 4 bytes + 32-bit accumulator hold exactly 4 codes
    ack_mode = 0;
    tick();
    log_q.delete(); alog_q.delete();
    acc_cnt = 0;
    stall_seen = 0;
    for (int k = 0; k < 12; k++) begin
      try_op(16, 16'h1234, ok_op);
      if (ok_op) acc_cnt++;
      else stall_seen = 1;
    end
    check("t4_stall_seen", stall_seen, 1);
    check("t4_accepted", acc_cnt, 4);
    ack_mode = 1;
    wait_idle(200);
    check("t4_len", log_q.size(), 2 * acc_cnt);
    for (int i = 0; i < log_q.size(); i++)
      check("t4_stream", log_q[i], (i % 2 == 0) ? 8'h12 : 8'h34);

    // address write while busy is refused and flags err
    spr_wr_t(2'd2, 32'h0000_3000);
    ack_mode = 0;
    tick();
    do_op(8, 16'h00A5);
    wait_store();
    spr_wr_t(2'd2, 32'h0000_5000);
    #1 check("t5_addr_kept", vlx_addr_o, 32'h3000);
    tick();
    spr_addr = 2'd0;
    #1 check("t5_err_set", spr_dat_o[31], 1);
    tick();
    spr_wr_t(2'd0, 32'h2);
    spr_addr = 2'd0;
    #1 check("t5_err_clr", spr_dat_o[31], 0);
    tick();
    log_q.delete(); alog_q.delete();
    ack_mode = 1;
    wait_idle(100);
    check("t5_len", log_q.size(), 1);
    if (log_q.size() == 1) check("t5_baddr", alog_q[0], 32'h3000);

    // reset mid-request
    ack_mode = 0;
    tick();
    do_op(8, 16'h005A);
    wait_store();
    rst_i = 1'b1;
    #1;
    check("t6_store_drop", store_byte_o, 0);
    check("t6_addr_rst", vlx_addr_o, RST_ADDR);
    tick();
    rst_i = 1'b0;
    ack_mode = 1;
    log_q.delete(); alog_q.delete();
    repeat (20) tick();
    check("t6_no_store", log_q.size(), 0);

    // random phase
    ack_mode = 2;
    for (int k = 0; k < 600; k++) begin
      set_bit_op_i = ($urandom_range(0, 2) != 0);
      num_bits_i = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
      dat_i = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      r = $urandom_range(0, 39);
      spr_cs = (r < 4);
      spr_write = (r < 4);
      spr_addr = (r < 4) ? 2'(r) : 2'($urandom_range(0, 3));
      spr_dat_i = (r == 0) ? 32'h1 : (r == 1) ? 32'h2 : $urandom;
      tick();
    end
    set_bit_op_i = 1'b0;
    spr_cs = 1'b0;
    spr_write = 1'b0;
    tick();
    spr_wr_t(2'd0, 32'h1);
    ack_mode = 1;
    wait_idle(2000);
    spr_rd(2'd3, 32'h0, "end_level");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
